// File: rtl/pattern_gen_if.sv
// Stream and control bundle for pattern_gen.
// The master modport is the generator side; the slave modport is the side that drives start and consumes data.
interface pattern_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_len;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_busy;
  logic             o_done;

  modport master (
    input  i_start,
    input  i_len,
    input  i_ready,
    output o_data,
    output o_valid,
    output o_busy,
    output o_done
  );

  modport slave (
    output i_start,
    output i_len,
    output i_ready,
    input  o_data,
    input  o_valid,
    input  o_busy,
    input  o_done
  );
endinterface

// File: rtl/pattern_gen.sv
// Valid/ready pattern source: emits i_len beats counting up from START_VAL, then pulses o_done.
// Define PATTERN_GEN_WRAP_EN for continuous mode, where passes repeat back to back until reset.
module pattern_gen #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] START_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  pattern_gen_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] len_q,   len_d;
  logic [WIDTH-1:0] beat_q,  beat_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic xfer;
  logic last_beat;

  // beat_q is the 1-based index of the beat on o_data, so it never depends on the data value or its wrap.
  assign xfer      = valid_q & bus.i_ready;
  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          len_d  = bus.i_len;
          data_d = START_VAL;
          beat_d = WIDTH'(1);
          if (bus.i_len != '0) begin
            state_d = RUN;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      RUN: begin
        if (xfer) begin
          if (last_beat) begin
`ifdef PATTERN_GEN_WRAP_EN
            data_d  = START_VAL;
            beat_d  = WIDTH'(1);
            done_d  = 1'b1;
`else
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            data_d = data_q + WIDTH'(1);
            beat_d = beat_q + WIDTH'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset wins over any transfer or start in the same cycle, so a pass aborts without an o_done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= START_VAL;
      len_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: two instances (START_VAL 0 and 254) share one stimulus stream.
// Expected beats are queued when a start is driven and compared every cycle while a beat should be valid.
module tb_pattern_gen;

  localparam int unsigned      W   = 8;
  localparam logic [W-1:0]     SV0 = 8'd0;
  localparam logic [W-1:0]     SV1 = 8'd254;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] len   = '0;
  logic         ready = 1'b0;

  pattern_gen_if #(.WIDTH(W)) bus0 ();
  pattern_gen_if #(.WIDTH(W)) bus1 ();

  assign bus0.i_start = start;
  assign bus0.i_len   = len;
  assign bus0.i_ready = ready;
  assign bus1.i_start = start;
  assign bus1.i_len   = len;
  assign bus1.i_ready = ready;

  pattern_gen #(.WIDTH(W), .START_VAL(SV0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pattern_gen #(.WIDTH(W), .START_VAL(SV1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] pass_len = '0;
  logic         done_due = 1'b0;
  logic         rst_seen = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushPass(input logic [W-1:0] l);
    for (int k = 0; k < int'(l); k++) begin
      q0.push_back(SV0 + W'(k));
      q1.push_back(SV1 + W'(k));
    end
  endtask

  // One clock cycle: check what the DUTs show now, update the scoreboard, then drive the next edge's inputs.
  task automatic applyStimulus(input logic s, input logic [W-1:0] l, input logic r, input logic nrst);
    logic exp_valid;
    logic done_next;
    logic idle;
    @(negedge clk);
    exp_valid = (q0.size() != 0);
    checkOutput("valid0", 32'(bus0.o_valid), 32'(exp_valid));
    checkOutput("busy0",  32'(bus0.o_busy),  32'(exp_valid));
    checkOutput("done0",  32'(bus0.o_done),  32'(done_due));
    checkOutput("valid1", 32'(bus1.o_valid), 32'(exp_valid));
    checkOutput("busy1",  32'(bus1.o_busy),  32'(exp_valid));
    checkOutput("done1",  32'(bus1.o_done),  32'(done_due));
    if (exp_valid) begin
      checkOutput("data0", 32'(bus0.o_data), 32'(q0[0]));
      checkOutput("data1", 32'(bus1.o_data), 32'(q1[0]));
    end else if (rst_seen) begin
      checkOutput("rstdata0", 32'(bus0.o_data), 32'(SV0));
      checkOutput("rstdata1", 32'(bus1.o_data), 32'(SV1));
    end

    done_next = 1'b0;
    if (!nrst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (exp_valid && r) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (q0.size() == 0) begin
          done_next = 1'b1;
`ifdef PATTERN_GEN_WRAP_EN
          pushPass(pass_len);
`endif
        end
      end
      idle = !exp_valid && !done_due;
      if (s && idle) begin
        pass_len = l;
        pushPass(l);
        if (l == '0) done_next = 1'b1;
      end
    end
    rst_seen = !nrst;
    done_due = done_next;
    start    = s;
    len      = l;
    ready    = r;
    rst      = nrst;
  endtask

  initial begin
    $display("[TB] pattern_gen bench starting");

    // Held in reset with a start request that must not be taken.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);

`ifdef PATTERN_GEN_WRAP_EN
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 8'd3, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b1, 8'd7, 1'(i % 3 != 1), 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'd1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
`else
    // First edge out of reset accepts a 10-beat pass with ready held high.
    applyStimulus(1'b1, 8'd10, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);

    applyStimulus(1'b1, 8'd4, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);

    // Zero-length pass, then a start pulse and length change mid-RUN that must be ignored.
    applyStimulus(1'b1, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'd6, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd6, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'd2, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'(i == 4), 8'd2, 1'b1, 1'b1);

    // Reset after the third beat of a 10-beat pass, then restart.
    applyStimulus(1'b1, 8'd10, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd10, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd10, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd10, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'd3, 1'b1, 1'b1);

    // Single beat stalled before it transfers.
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd1, 1'b1, 1'b1);

    // Random backpressure, then a reset while stalled.
    applyStimulus(1'b1, 8'd20, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 8'd20, 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'd20, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'd9, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd9, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd9, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd9, 1'b1, 1'b1);

    // Maximum length: the 254 instance wraps its data while the beat count runs to 255.
    applyStimulus(1'b1, 8'd255, 1'b1, 1'b1);
    for (int i = 0; i < 258; i++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
`endif

    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data and length width in bits.
REQ-002 SHALL have parameter START_VAL, default 0, first data value of each pass.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1  start request, sampled in IDLE only.
REQ-006 SHALL have port i_len  input  WIDTH  beats per pass, latched on accepted start.
REQ-007 SHALL have port i_ready  input  1  downstream stage can accept o_data this cycle.
REQ-008 SHALL have port o_data  output  WIDTH  generated sample feeding the downstream stage's i_data.
REQ-009 SHALL have port o_valid  output  1  o_data holds a valid beat.
REQ-010 SHALL have port o_busy  output  1  high in RUN.
REQ-011 SHALL have port o_done  output  1  one-cycle pass-complete pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; all outputs registered.
REQ-013 IDLE: i_start=1 -> latch i_len and load counter with START_VAL; go to RUN if i_len!=0, else go to DONE.
REQ-014 Latency: start accepted at edge N -> o_valid=1 and o_data=START_VAL from cycle after edge N.
REQ-015 RUN: o_valid=1; a beat transfers on a rising edge with o_valid=1 and i_ready=1.
REQ-016 o_valid=1 and i_ready=0 -> o_data and o_valid SHALL hold stable; no counter advance.
REQ-017 Each transfer -> o_data increments by 1 modulo 2^WIDTH; all-ones wraps to 0 silently.
REQ-018 Transfer of beat i_len (last) -> go to DONE; o_valid=0 from the next cycle.
REQ-019 DONE: o_done=1 for exactly one cycle, o_busy=0, o_valid=0; then go to IDLE.
REQ-020 i_start in RUN or DONE SHALL be ignored; i_len changes after latch SHALL have no effect.
REQ-021 i_len max 2^WIDTH-1 beats; beat count is independent of START_VAL and of data wrap.
REQ-022 o_busy=1 exactly while in RUN.

Reset
REQ-023 rst=0 at a rising edge -> IDLE, o_valid=0, o_busy=0, o_done=0, o_data=START_VAL, length register=0.
REQ-024 Reset mid-pass SHALL abort the pass immediately with no o_done pulse.
REQ-025 i_start asserted during reset SHALL be ignored; the earliest start is accepted on the first edge with rst=1.

Configuration
REQ-026 Macro PATTERN_GEN_WRAP_EN SHALL select continuous mode.
REQ-027 With PATTERN_GEN_WRAP_EN: transfer of the last beat -> stay in RUN, counter reloads START_VAL, o_valid stays 1 with no gap, o_done pulses one cycle after every pass; i_len=0 behaves as in REQ-013; RUN exits only on reset.
REQ-028 Without PATTERN_GEN_WRAP_EN: one pass per start, exactly per REQ-018 to REQ-019; no continuous-mode logic synthesized.

Verification
REQ-029 Reset 3 cycles, start i_len=10, i_ready=1 -> o_data 0..9 on 10 consecutive cycles, then o_done pulse, o_busy=0.
REQ-030 i_len=4, i_ready toggled 1,0,0,1,1,0,1 -> beats 0,1,2,3 each held while stalled, 4 transfers only, then o_done.
REQ-031 START_VAL=254, WIDTH=8, i_len=4 -> o_data 254,255,0,1, then o_done.
REQ-032 i_len=0 -> o_valid never 1, o_done pulses the cycle after start; i_start pulse mid-RUN -> ignored, beat count unchanged.
REQ-033 rst=0 after the 3rd beat of i_len=10 -> next cycle o_valid=0, o_data=START_VAL, no o_done; new start -> restarts from START_VAL.
REQ-034 PATTERN_GEN_WRAP_EN, i_len=3, i_ready=1 -> o_data 0,1,2,0,1,2... with no gap, o_done pulsing every 3 cycles.
